// File: rtl/syscall_unit_pkg.sv
// Shared definitions for the SYSCALL unit: service codes, console kinds,
// controller states and the $v0 service decoder.
package syscall_unit_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SYS_EXIT       = 32'd10;

  localparam logic [1:0] CON_INT  = 2'd0;
  localparam logic [1:0] CON_CHAR = 2'd1;

  typedef enum logic [2:0] {
    SC_IDLE    = 3'd0,
    SC_DRAIN   = 3'd1,
    SC_READ    = 3'd2,
    SC_EMIT    = 3'd3,
    SC_RELEASE = 3'd4,
    SC_HALT    = 3'd5
  } sc_state_e;

  typedef enum logic [1:0] {
    SVC_INT,
    SVC_CHAR,
    SVC_EXIT,
    SVC_BAD
  } svc_e;

  function automatic svc_e decode_service(input logic [31:0] v0);
    svc_e svc;
    case (v0)
      SYS_PRINT_INT:  svc = SVC_INT;
      SYS_PRINT_CHAR: svc = SVC_CHAR;
      SYS_EXIT:       svc = SVC_EXIT;
      default:        svc = SVC_BAD;
    endcase
    return svc;
  endfunction

endpackage

// File: rtl/syscall_unit.sv
// SYSCALL execution unit beside decode: stalls, drains, reads $v0/$a0, runs the
// console service, then releases or halts. SYSCALL_TIMEOUT_EN adds a console wait limit.
module syscall_unit
  import syscall_unit_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_id,
  input  logic [31:0] reg_v0,
  input  logic [31:0] reg_a0,
  output logic        stall,
  output logic        bubble_ex,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [1:0]  con_kind,
  output logic [31:0] con_data,
  output logic        halted,
  output logic        bad_syscall,
  output logic        timeout_err
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  if (DRAIN_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("syscall_unit: DRAIN_CYCLES and TIMEOUT_CYCLES must be non-zero");
  end

  sc_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   v0_q, a0_q;
  logic          halted_q, halt_set;
  logic          timeout_set;
  svc_e          svc;

  assign svc = decode_service(v0_q);

`ifdef SYSCALL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_q;
  logic          timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == SC_READ)
        wait_q <= '0;
      else if (state_q == SC_EMIT && con_valid && !con_ready)
        wait_q <= wait_q + 1'b1;
      if (timeout_set)
        timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SC_IDLE;
      cnt_q    <= '0;
      v0_q     <= '0;
      a0_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == SC_READ) begin
        v0_q <= reg_v0;
        a0_q <= reg_a0;
      end
      if (halt_set)
        halted_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    bubble_ex   = 1'b0;
    con_valid   = 1'b0;
    con_kind    = CON_INT;
    con_data    = '0;
    bad_syscall = 1'b0;
    halt_set    = 1'b0;
    timeout_set = 1'b0;

    case (state_q)
      SC_IDLE: begin
        if (syscall_id) begin
          stall     = 1'b1;
          bubble_ex = 1'b1;
          cnt_d     = DRAIN_LOAD;
          state_d   = SC_DRAIN;
        end
      end
      SC_DRAIN: begin
        stall     = 1'b1;
        bubble_ex = 1'b1;
        if (cnt_q == '0)
          state_d = SC_READ;
        else
          cnt_d = cnt_q - 1'b1;
      end
      SC_READ: begin
        stall     = 1'b1;
        bubble_ex = 1'b1;
        state_d   = SC_EMIT;
      end
      SC_EMIT: begin
        stall     = 1'b1;
        bubble_ex = 1'b1;
        case (svc)
          SVC_INT: begin
            con_valid = 1'b1;
            con_kind  = CON_INT;
            con_data  = a0_q;
            if (con_ready)
              state_d = SC_RELEASE;
          end
          SVC_CHAR: begin
            con_valid = 1'b1;
            con_kind  = CON_CHAR;
            con_data  = {24'b0, a0_q[7:0]};
            if (con_ready)
              state_d = SC_RELEASE;
          end
          SVC_EXIT: begin
            halt_set = 1'b1;
            state_d  = SC_HALT;
          end
          default: begin
            bad_syscall = 1'b1;
            state_d     = SC_RELEASE;
          end
        endcase
`ifdef SYSCALL_TIMEOUT_EN
        // Abandon the request on the last waiting cycle; con_valid drops in RELEASE.
        if (con_valid && !con_ready && wait_q == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_d     = SC_RELEASE;
        end
`endif
      end
      SC_RELEASE: begin
        state_d = SC_IDLE;
      end
      SC_HALT: begin
        stall     = 1'b1;
        bubble_ex = 1'b1;
      end
      default: begin
        state_d = SC_IDLE;
      end
    endcase
  end

  assign halted = halted_q;

endmodule
